// File: rtl/crc_pkt_buffer.sv
// crc_pkt_buffer
//   Store-and-forward packet buffer placed after a CRC checker. Incoming
//   beats are written speculatively behind commit_ptr. On a good verdict
//   the payload (trailing CRC byte excluded) is committed and its length
//   queued. On a bad verdict, overflow or timeout the write pointer rewinds.
//   Committed packets are replayed on a valid/ready stream with sop/eop.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_sop, wr_eop        packet framing pulses (no data)
//   wr_valid, wr_data     packet beats; the last beat is the CRC byte
//   crc_done, crc_pass    checker verdict strobe and result
//   rd_ready              downstream accepts the current rd beat
//   rd_valid, rd_data     payload beat out
//   rd_sop, rd_eop        first / last beat of a packet
//   pkt_drop, pkt_commit  one-cycle status pulses
//   pkt_cnt               committed packets not yet fully read
module crc_pkt_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int LEN_DEPTH   = 8,
  parameter int CRC_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_sop,
  input  logic                        wr_eop,
  input  logic                        wr_valid,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        crc_done,
  input  logic                        crc_pass,
  input  logic                        rd_ready,
  output logic                        rd_valid,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_sop,
  output logic                        rd_eop,
  output logic                        pkt_drop,
  output logic                        pkt_commit,
  output logic [$clog2(LEN_DEPTH):0]  pkt_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int LAW = $clog2(LEN_DEPTH);
  localparam int LPW = LAW + 1;
  localparam int TW  = $clog2(CRC_TIMEOUT) + 1;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_RECV = 2'd1, W_CRC_WAIT = 2'd2} wr_state_e;
  typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_e;

  wr_state_e wr_state_r, wr_state_s;
  rd_state_e rd_state_r, rd_state_s;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         lf_mem_r [LEN_DEPTH];

  logic [PW-1:0]  wr_ptr_r, commit_ptr_r, rd_ptr_r, cnt_r;
  logic           ovf_r;
  logic [TW-1:0]  timer_r;
  logic [LPW-1:0] lf_wr_r, lf_rd_r, lf_count_s;
  logic           lf_full_s, lf_empty_s;
  logic [PW-1:0]  lf_head_s;

  logic           full_s, timer_max_s;
  logic           write_s, ovf_set_s, verdict_s, timeout_drop_s, preempt_drop_s;
  logic [PW-1:0]  eff_ptr_s, eff_cnt_s;
  logic           eff_ovf_s, good_s, commit_s, drop_s;

  logic           accept_s, last_s, load_s, step_s;
  logic [PW-1:0]  rd_next_ptr_s;
  logic [PW-1:0]  len_r, beat_r;

  logic                  rd_valid_r, rd_sop_r, rd_eop_r, pkt_drop_r, pkt_commit_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [LPW-1:0]        pkt_cnt_r;

  // Uncommitted writes may use every slot not yet read back.
  assign full_s      = (wr_ptr_r - rd_ptr_r) == PW'(DEPTH);
  assign timer_max_s = timer_r == TW'(CRC_TIMEOUT - 1);
  assign lf_count_s  = lf_wr_r - lf_rd_r;
  assign lf_full_s   = lf_count_s == LPW'(LEN_DEPTH);
  assign lf_empty_s  = lf_count_s == LPW'(0);
  assign lf_head_s   = lf_mem_r[lf_rd_r[LAW-1:0]];

  // Write FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state_r <= W_IDLE;
    else        wr_state_r <= wr_state_s;
  end

  // Write FSM next state; a new sop always restarts reception
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      W_IDLE:     if (wr_sop) wr_state_s = W_RECV; else wr_state_s = W_IDLE;
      W_RECV: begin
        if (wr_sop)                    wr_state_s = W_RECV;
        else if (wr_eop && crc_done)   wr_state_s = W_IDLE;
        else if (wr_eop)               wr_state_s = W_CRC_WAIT;
        else                           wr_state_s = W_RECV;
      end
      W_CRC_WAIT: begin
        if (wr_sop)                        wr_state_s = W_RECV;
        else if (crc_done || timer_max_s)  wr_state_s = W_IDLE;
        else                               wr_state_s = W_CRC_WAIT;
      end
      default:    wr_state_s = W_IDLE;
    endcase
  end

  // Write FSM actions. The eff_* values include this cycle's beat so a
  // verdict arriving together with eop (and the CRC beat) sees it.
  always_comb begin
    write_s        = 1'b0;
    ovf_set_s      = 1'b0;
    verdict_s      = 1'b0;
    timeout_drop_s = 1'b0;
    preempt_drop_s = 1'b0;
    case (wr_state_r)
      W_RECV: begin
        write_s   = ~wr_sop & wr_valid & ~full_s;
        ovf_set_s = ~wr_sop & wr_valid & full_s;
        verdict_s = ~wr_sop & wr_eop & crc_done;
      end
      W_CRC_WAIT: begin
        verdict_s      = ~wr_sop & crc_done;
        timeout_drop_s = ~wr_sop & ~crc_done & timer_max_s;
        preempt_drop_s = wr_sop;
      end
      default: begin
        write_s = 1'b0;
      end
    endcase
    eff_ptr_s = wr_ptr_r + PW'(write_s);
    eff_cnt_s = cnt_r + PW'(write_s);
    eff_ovf_s = ovf_r | ovf_set_s;
    good_s    = crc_pass & ~eff_ovf_s & (eff_cnt_s >= PW'(2)) & ~lf_full_s;
    commit_s  = verdict_s & good_s;
    drop_s    = (verdict_s & ~good_s) | timeout_drop_s | preempt_drop_s;
  end

  // Write-side pointers, beat count, overflow flag and verdict timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= PW'(0);
      commit_ptr_r <= PW'(0);
      cnt_r        <= PW'(0);
      ovf_r        <= 1'b0;
      timer_r      <= TW'(0);
    end else begin
      if (wr_sop || drop_s) wr_ptr_r <= commit_ptr_r;
      else                  wr_ptr_r <= eff_ptr_s;
      // commit point sits just before the CRC byte
      if (commit_s) commit_ptr_r <= eff_ptr_s - PW'(1);
      else          commit_ptr_r <= commit_ptr_r;
      if (wr_sop) begin
        cnt_r <= PW'(0);
        ovf_r <= 1'b0;
      end else begin
        cnt_r <= eff_cnt_s;
        ovf_r <= eff_ovf_s;
      end
      if (wr_state_r == W_CRC_WAIT) timer_r <= timer_r + TW'(1);
      else                          timer_r <= TW'(0);
    end
  end

  // Payload RAM write port
  always_ff @(posedge clk) begin
    if (write_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

  // Length FIFO storage; length excludes the CRC byte
  always_ff @(posedge clk) begin
    if (commit_s) lf_mem_r[lf_wr_r[LAW-1:0]] <= eff_cnt_s - PW'(1);
  end

  // Length FIFO pointers; the head is popped only once its eop beat is
  // accepted, so a packet being replayed still occupies its entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf_wr_r <= LPW'(0);
      lf_rd_r <= LPW'(0);
    end else begin
      if (commit_s) lf_wr_r <= lf_wr_r + LPW'(1);
      else          lf_wr_r <= lf_wr_r;
      if (last_s)   lf_rd_r <= lf_rd_r + LPW'(1);
      else          lf_rd_r <= lf_rd_r;
    end
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state_r <= RD_IDLE;
    else        rd_state_r <= rd_state_s;
  end

  // Read FSM next state
  always_comb begin
    rd_state_s = rd_state_r;
    case (rd_state_r)
      RD_IDLE: if (!lf_empty_s) rd_state_s = RD_DATA; else rd_state_s = RD_IDLE;
      RD_DATA: if (last_s)      rd_state_s = RD_IDLE; else rd_state_s = RD_DATA;
      default: rd_state_s = RD_IDLE;
    endcase
  end

  // Read FSM actions
  always_comb begin
    accept_s      = rd_valid_r & rd_ready;
    last_s        = accept_s & rd_eop_r;
    load_s        = 1'b0;
    step_s        = 1'b0;
    rd_next_ptr_s = rd_ptr_r + PW'(1);
    case (rd_state_r)
      RD_IDLE: load_s = ~lf_empty_s;
      RD_DATA: step_s = accept_s & ~rd_eop_r;
      default: load_s = 1'b0;
    endcase
  end

  // Read-side pointer and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r   <= PW'(0);
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_sop_r   <= 1'b0;
      rd_eop_r   <= 1'b0;
      len_r      <= PW'(0);
      beat_r     <= PW'(0);
    end else begin
      if (accept_s) rd_ptr_r <= rd_next_ptr_s;
      else          rd_ptr_r <= rd_ptr_r;
      if (load_s) begin
        rd_valid_r <= 1'b1;
        rd_data_r  <= mem_r[rd_ptr_r[AW-1:0]];
        rd_sop_r   <= 1'b1;
        rd_eop_r   <= lf_head_s == PW'(1);
        len_r      <= lf_head_s;
        beat_r     <= PW'(1);
      end else if (step_s) begin
        rd_data_r  <= mem_r[rd_next_ptr_s[AW-1:0]];
        rd_sop_r   <= 1'b0;
        rd_eop_r   <= (beat_r + PW'(1)) == len_r;
        beat_r     <= beat_r + PW'(1);
      end else if (last_s) begin
        rd_valid_r <= 1'b0;
        rd_sop_r   <= 1'b0;
        rd_eop_r   <= 1'b0;
      end else begin
        rd_valid_r <= rd_valid_r;
      end
    end
  end

  // Status pulses and committed-packet counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_commit_r <= 1'b0;
      pkt_drop_r   <= 1'b0;
      pkt_cnt_r    <= LPW'(0);
    end else begin
      pkt_commit_r <= commit_s;
      pkt_drop_r   <= drop_s;
      case ({commit_s, last_s})
        2'b10:   pkt_cnt_r <= pkt_cnt_r + LPW'(1);
        2'b01:   pkt_cnt_r <= pkt_cnt_r - LPW'(1);
        default: pkt_cnt_r <= pkt_cnt_r;
      endcase
    end
  end

  assign rd_valid   = rd_valid_r;
  assign rd_data    = rd_data_r;
  assign rd_sop     = rd_sop_r;
  assign rd_eop     = rd_eop_r;
  assign pkt_drop   = pkt_drop_r;
  assign pkt_commit = pkt_commit_r;
  assign pkt_cnt    = pkt_cnt_r;

endmodule

// File: tb/tb_crc_pkt_buffer.sv
module tb_crc_pkt_buffer;
  logic       clk;
  logic       rst_n;
  logic       wr_sop, wr_eop, wr_valid, crc_done, crc_pass, rd_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_sop, rd_eop, pkt_drop, pkt_commit;
  logic [7:0] rd_data;
  logic [3:0] pkt_cnt;

  int checks = 0;
  int fails  = 0;

  logic [7:0] pkt_buf [0:127];
  logic [7:0] obs_data [0:15];
  logic       obs_sop [0:15];
  logic       obs_eop [0:15];
  int         got, unstable;

  crc_pkt_buffer #(.DATA_WIDTH(8), .DEPTH(64), .LEN_DEPTH(8), .CRC_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_valid(wr_valid),
    .wr_data(wr_data), .crc_done(crc_done), .crc_pass(crc_pass), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_sop(rd_sop), .rd_eop(rd_eop),
    .pkt_drop(pkt_drop), .pkt_commit(pkt_commit), .pkt_cnt(pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  // sop, n beats from pkt_buf, eop (optionally on the last beat), optional verdict at eop
  task automatic write_pkt(input int n, input bit merge, input bit done_at_eop, input bit pass);
    @(negedge clk); wr_sop = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); wr_sop = 1'b0; wr_valid = 1'b1; wr_data = pkt_buf[i];
      if (merge && i == n - 1) begin wr_eop = 1'b1; crc_done = done_at_eop; crc_pass = pass; end
    end
    if (!merge) begin
      @(negedge clk); wr_valid = 1'b0; wr_eop = 1'b1; crc_done = done_at_eop; crc_pass = pass;
    end
    @(negedge clk); wr_valid = 1'b0; wr_eop = 1'b0; crc_done = 1'b0; crc_pass = 1'b0;
  endtask

  task automatic do_verdict(input bit pass);
    @(negedge clk); crc_done = 1'b1; crc_pass = pass;
    @(negedge clk); crc_done = 1'b0; crc_pass = 1'b0;
  endtask

  // Records accepted beats and counts changes of a stalled beat; bounded
  task automatic collect(input int n, input bit toggle);
    logic       r = 1'b0;
    logic       held = 1'b0;
    logic [7:0] h_data = 8'h00;
    logic       h_sop = 1'b0, h_eop = 1'b0;
    int         cyc = 0;
    got = 0; unstable = 0;
    while (got < n && cyc < 400) begin
      @(negedge clk); cyc++;
      if (held && (!rd_valid || rd_data !== h_data || rd_sop !== h_sop || rd_eop !== h_eop)) unstable++;
      held = 1'b0;
      r = toggle ? ~r : 1'b1;
      rd_ready = r;
      if (rd_valid && r) begin
        obs_data[got] = rd_data; obs_sop[got] = rd_sop; obs_eop[got] = rd_eop; got++;
      end else if (rd_valid) begin
        held = 1'b1; h_data = rd_data; h_sop = rd_sop; h_eop = rd_eop;
      end
    end
    @(negedge clk); rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rd_valid !== 1'b0 || rd_sop !== 1'b0 || rd_eop !== 1'b0) begin fails++; $display("FAIL reset_rd_flags: got v%0b s%0b e%0b expected 0", rd_valid, rd_sop, rd_eop); end
    checks++; if (rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    checks++; if (pkt_drop !== 1'b0 || pkt_commit !== 1'b0) begin fails++; $display("FAIL reset_pulses: got d%0b c%0b expected 0", pkt_drop, pkt_commit); end
    checks++; if (pkt_cnt !== 4'd0) begin fails++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_commit();
    logic [7:0] e [3] = '{8'h11, 8'h22, 8'h33};
    pkt_buf[0] = 8'h11; pkt_buf[1] = 8'h22; pkt_buf[2] = 8'h33; pkt_buf[3] = 8'hA5;
    write_pkt(4, 1'b0, 1'b0, 1'b0);
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL commit_pre_valid: got %0b expected 0", rd_valid); end
    do_verdict(1'b1);
    checks++; if (pkt_commit !== 1'b1 || pkt_drop !== 1'b0) begin fails++; $display("FAIL commit_pulse: got c%0b d%0b expected c1 d0", pkt_commit, pkt_drop); end
    checks++; if (pkt_cnt !== 4'd1) begin fails++; $display("FAIL commit_cnt: got %0d expected 1", pkt_cnt); end
    collect(3, 1'b0);
    checks++; if (got !== 3) begin fails++; $display("FAIL commit_beats: got %0d expected 3", got); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_data[i] !== e[i] || obs_sop[i] !== (i == 0) || obs_eop[i] !== (i == 2)) begin
        fails++; $display("FAIL commit_beat%0d: got %0h s%0b e%0b expected %0h s%0b e%0b", i, obs_data[i], obs_sop[i], obs_eop[i], e[i], i == 0, i == 2);
      end
    end
    checks++; if (pkt_cnt !== 4'd0) begin fails++; $display("FAIL commit_cnt_after: got %0d expected 0", pkt_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL commit_no_crc_byte: got rd_valid %0b expected 0", rd_valid); end
  endtask

  task automatic test_drop();
    pkt_buf[0] = 8'h11; pkt_buf[1] = 8'h22; pkt_buf[2] = 8'h33; pkt_buf[3] = 8'h5A;
    write_pkt(4, 1'b0, 1'b0, 1'b0);
    do_verdict(1'b0);
    checks++; if (pkt_drop !== 1'b1 || pkt_commit !== 1'b0) begin fails++; $display("FAIL drop_pulse: got d%0b c%0b expected d1 c0", pkt_drop, pkt_commit); end
    repeat (4) @(negedge clk);
    checks++; if (rd_valid !== 1'b0 || pkt_cnt !== 4'd0) begin fails++; $display("FAIL drop_idle: got v%0b cnt%0d expected v0 cnt0", rd_valid, pkt_cnt); end
    pkt_buf[0] = 8'h44; pkt_buf[1] = 8'h55; pkt_buf[2] = 8'hC3;
    write_pkt(3, 1'b0, 1'b0, 1'b0);
    do_verdict(1'b1);
    checks++; if (pkt_commit !== 1'b1) begin fails++; $display("FAIL drop_next_commit: got %0b expected 1", pkt_commit); end
    collect(2, 1'b0);
    checks++;
    if (got !== 2 || obs_data[0] !== 8'h44 || obs_data[1] !== 8'h55 || obs_sop[0] !== 1'b1 || obs_eop[1] !== 1'b1 || obs_eop[0] !== 1'b0) begin
      fails++; $display("FAIL drop_next_data: got n%0d %0h %0h expected n2 44 55 with sop/eop", got, obs_data[0], obs_data[1]);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) pkt_buf[i] = 8'h60 + 8'(i);
    pkt_buf[5] = 8'h99;
    write_pkt(6, 1'b0, 1'b0, 1'b0);
    do_verdict(1'b1);
    checks++; if (pkt_commit !== 1'b1) begin fails++; $display("FAIL ovf_prior_commit: got %0b expected 1", pkt_commit); end
    for (int i = 0; i < 70; i++) pkt_buf[i] = 8'(i);
    write_pkt(70, 1'b0, 1'b0, 1'b0);
    do_verdict(1'b1);
    checks++; if (pkt_drop !== 1'b1 || pkt_commit !== 1'b0) begin fails++; $display("FAIL ovf_drop: got d%0b c%0b expected d1 c0", pkt_drop, pkt_commit); end
    checks++; if (pkt_cnt !== 4'd1) begin fails++; $display("FAIL ovf_cnt: got %0d expected 1", pkt_cnt); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h60 || rd_sop !== 1'b1) begin fails++; $display("FAIL ovf_head_held: got v%0b %0h s%0b expected v1 60 s1", rd_valid, rd_data, rd_sop); end
    collect(5, 1'b0);
    checks++; if (got !== 5) begin fails++; $display("FAIL ovf_beats: got %0d expected 5", got); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_data[i] !== 8'h60 + 8'(i) || obs_eop[i] !== (i == 4)) begin
        fails++; $display("FAIL ovf_beat%0d: got %0h e%0b expected %0h e%0b", i, obs_data[i], obs_eop[i], 8'h60 + 8'(i), i == 4);
      end
    end
    checks++; if (pkt_cnt !== 4'd0) begin fails++; $display("FAIL ovf_cnt_after: got %0d expected 0", pkt_cnt); end
  endtask

  task automatic test_timeout();
    pkt_buf[0] = 8'h77; pkt_buf[1] = 8'h88; pkt_buf[2] = 8'hE1;
    write_pkt(3, 1'b0, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    checks++; if (pkt_drop !== 1'b0) begin fails++; $display("FAIL timeout_early: got %0b expected 0", pkt_drop); end
    @(negedge clk);
    checks++; if (pkt_drop !== 1'b1 || pkt_commit !== 1'b0) begin fails++; $display("FAIL timeout_drop: got d%0b c%0b expected d1 c0", pkt_drop, pkt_commit); end
    @(negedge clk);
    checks++; if (pkt_drop !== 1'b0 || rd_valid !== 1'b0) begin fails++; $display("FAIL timeout_after: got d%0b v%0b expected 0 0", pkt_drop, rd_valid); end
    pkt_buf[0] = 8'h99; pkt_buf[1] = 8'hAA; pkt_buf[2] = 8'h0F;
    write_pkt(3, 1'b0, 1'b0, 1'b0);
    do_verdict(1'b1);
    checks++; if (pkt_commit !== 1'b1) begin fails++; $display("FAIL timeout_next_commit: got %0b expected 1", pkt_commit); end
    collect(2, 1'b0);
    checks++;
    if (got !== 2 || obs_data[0] !== 8'h99 || obs_data[1] !== 8'hAA || obs_sop[0] !== 1'b1 || obs_eop[1] !== 1'b1) begin
      fails++; $display("FAIL timeout_next_data: got n%0d %0h %0h expected n2 99 aa", got, obs_data[0], obs_data[1]);
    end
  endtask

  task automatic test_len_full();
    int ncommit = 0;
    int ndrop   = 0;
    logic last_drop = 1'b0;
    rd_ready = 1'b0;
    for (int p = 0; p < 9; p++) begin
      pkt_buf[0] = 8'hB0 + 8'(p); pkt_buf[1] = 8'hCC;
      write_pkt(2, 1'b0, 1'b0, 1'b0);
      do_verdict(1'b1);
      if (pkt_commit === 1'b1) ncommit++;
      if (pkt_drop === 1'b1) ndrop++;
      if (p == 8) last_drop = pkt_drop;
    end
    checks++; if (ncommit !== 8 || ndrop !== 1) begin fails++; $display("FAIL lenfull_counts: got c%0d d%0d expected c8 d1", ncommit, ndrop); end
    checks++; if (last_drop !== 1'b1) begin fails++; $display("FAIL lenfull_ninth: got %0b expected 1", last_drop); end
    checks++; if (pkt_cnt !== 4'd8) begin fails++; $display("FAIL lenfull_cnt: got %0d expected 8", pkt_cnt); end
    collect(8, 1'b0);
    checks++; if (got !== 8) begin fails++; $display("FAIL lenfull_beats: got %0d expected 8", got); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_data[i] !== 8'hB0 + 8'(i) || obs_sop[i] !== 1'b1 || obs_eop[i] !== 1'b1) begin
        fails++; $display("FAIL lenfull_beat%0d: got %0h s%0b e%0b expected %0h s1 e1", i, obs_data[i], obs_sop[i], obs_eop[i], 8'hB0 + 8'(i));
      end
    end
    checks++; if (pkt_cnt !== 4'd0) begin fails++; $display("FAIL lenfull_cnt_after: got %0d expected 0", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [5]  = '{8'hC1, 8'hC2, 8'hC3, 8'hD1, 8'hD2};
    logic       es [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       ee [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pkt_buf[0] = 8'hC1; pkt_buf[1] = 8'hC2; pkt_buf[2] = 8'hC3; pkt_buf[3] = 8'h3C;
    write_pkt(4, 1'b0, 1'b0, 1'b0);
    do_verdict(1'b1);
    checks++; if (pkt_commit !== 1'b1) begin fails++; $display("FAIL b2b_commit1: got %0b expected 1", pkt_commit); end
    // eop on the CRC beat with the verdict in the same cycle
    pkt_buf[0] = 8'hD1; pkt_buf[1] = 8'hD2; pkt_buf[2] = 8'h2D;
    write_pkt(3, 1'b1, 1'b1, 1'b1);
    checks++; if (pkt_commit !== 1'b1) begin fails++; $display("FAIL b2b_commit_at_eop: got %0b expected 1", pkt_commit); end
    checks++; if (pkt_cnt !== 4'd2) begin fails++; $display("FAIL b2b_cnt: got %0d expected 2", pkt_cnt); end
    collect(5, 1'b1);
    checks++; if (got !== 5) begin fails++; $display("FAIL b2b_beats: got %0d expected 5", got); end
    checks++; if (unstable !== 0) begin fails++; $display("FAIL b2b_stall_stable: got %0d changes expected 0", unstable); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_data[i] !== e[i] || obs_sop[i] !== es[i] || obs_eop[i] !== ee[i]) begin
        fails++; $display("FAIL b2b_beat%0d: got %0h s%0b e%0b expected %0h s%0b e%0b", i, obs_data[i], obs_sop[i], obs_eop[i], e[i], es[i], ee[i]);
      end
    end
    checks++; if (pkt_cnt !== 4'd0) begin fails++; $display("FAIL b2b_cnt_after: got %0d expected 0", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); wr_sop = 1'b1;
    @(negedge clk); wr_sop = 1'b0; wr_valid = 1'b1; wr_data = 8'hE7;
    @(negedge clk); wr_data = 8'hE8;
    @(negedge clk); wr_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++; if (pkt_drop !== 1'b0 || pkt_commit !== 1'b0 || rd_valid !== 1'b0) begin fails++; $display("FAIL rstmid_quiet: got d%0b c%0b v%0b expected 0", pkt_drop, pkt_commit, rd_valid); end
    rst_n = 1'b1;
    @(negedge clk); wr_eop = 1'b1;
    @(negedge clk); wr_eop = 1'b0;
    do_verdict(1'b1);
    checks++; if (pkt_commit !== 1'b0 || pkt_drop !== 1'b0) begin fails++; $display("FAIL rstmid_no_verdict: got c%0b d%0b expected 0", pkt_commit, pkt_drop); end
    repeat (3) @(negedge clk);
    checks++; if (rd_valid !== 1'b0 || pkt_cnt !== 4'd0) begin fails++; $display("FAIL rstmid_empty: got v%0b cnt%0d expected 0", rd_valid, pkt_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    crc_done = 1'b0; crc_pass = 1'b0; rd_ready = 1'b0;
    test_reset();
    test_commit();
    test_drop();
    test_overflow();
    test_timeout();
    test_len_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
